// File: rtl/dec_inst_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of {inst, pc, taken} with a show-ahead head and opcode predecode.
// Optional same-cycle empty-queue bypass is enabled by defining DEC_IQ_BYPASS_EN.
module dec_inst_queue #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             inst_vld,
    input  logic [XLEN-1:0]  inst,
    input  logic [XLEN-1:0]  inst_pc,
    input  logic             inst_taken,
    output logic             iq_ready,
    input  logic             dec_ready,
    input  logic             alu_flush,
    output logic             iq_vld,
    output logic [XLEN-1:0]  iq_inst,
    output logic [XLEN-1:0]  iq_pc,
    output logic             iq_taken,
    output logic             iq_is_ctrl,
    output logic             iq_is_mem,
    output logic             iq_is_sys,
    output logic [PTR_W:0]   iq_count
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0]  inst_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             stored_vld;
    logic             full;
    logic             push;
    logic             pop;
    logic             byp_consume;
    logic [XLEN-1:0]  head_inst;
    logic [XLEN-1:0]  head_pc;
    logic             head_taken;
    logic [6:0]       opcode;

    assign stored_vld = (count != '0);
    assign full       = (count == (PTR_W+1)'(DEPTH));

`ifdef DEC_IQ_BYPASS_EN
    logic bypass;
    // An empty queue forwards the offered instruction straight to the head.
    assign bypass      = ~stored_vld & inst_vld;
    assign iq_vld      = (stored_vld | bypass) & ~alu_flush;
    assign byp_consume = bypass & dec_ready & ~alu_flush;
    assign head_inst   = stored_vld ? inst_mem[rd_ptr]  : inst;
    assign head_pc     = stored_vld ? pc_mem[rd_ptr]    : inst_pc;
    assign head_taken  = stored_vld ? taken_mem[rd_ptr] : inst_taken;
`else
    assign iq_vld      = stored_vld;
    assign byp_consume = 1'b0;
    assign head_inst   = inst_mem[rd_ptr];
    assign head_pc     = pc_mem[rd_ptr];
    assign head_taken  = taken_mem[rd_ptr];
`endif

    // Handshake: an instruction moves from fetch when inst_vld & iq_ready, and leaves
    // the head when iq_vld & dec_ready; alu_flush overrides both so nothing transfers.
    assign iq_ready = ~full | (iq_vld & dec_ready);
    assign push     = inst_vld & iq_ready & ~alu_flush & ~byp_consume;
    assign pop      = stored_vld & dec_ready & ~alu_flush;

    assign iq_inst  = iq_vld ? head_inst  : '0;
    assign iq_pc    = iq_vld ? head_pc    : '0;
    assign iq_taken = iq_vld & head_taken;
    assign iq_count = count;

    assign opcode     = iq_inst[6:0];
    assign iq_is_ctrl = iq_vld & ((opcode == OP_JAL) | (opcode == OP_JALR) | (opcode == OP_BRANCH));
    assign iq_is_mem  = iq_vld & ((opcode == OP_LOAD) | (opcode == OP_STORE));
    assign iq_is_sys  = iq_vld & (opcode == OP_SYSTEM);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (alu_flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; the head is masked by iq_vld until written.
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[wr_ptr]  <= inst;
            pc_mem[wr_ptr]    <= inst_pc;
            taken_mem[wr_ptr] <= inst_taken;
        end
    end

endmodule
